modsq_sequencer: RTL and testbench

MODSQ_SEQUENCER -- requirements
Module: modsq_sequencer

---
 rtl/modsq_sequencer.sv | 171 +++++++++++++++++
 tb/tb_modsq_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/modsq_sequencer.sv
// Drives an external squarer for T iterations of one value and returns the last result with ok/abort/timeout/invalid status.
// One cycle from accept to sq_start; the result is held in DONE until res_ready, and no new job is accepted meanwhile.
module modsq_sequencer #(
  parameter int MOD_LEN     = 1024,
  parameter int SQ_OUT_BITS = 2176,
  parameter int ITER_W      = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [MOD_LEN-1:0]     job_x,
  input  logic [ITER_W-1:0]      job_iters,
  input  logic                   abort,
  output logic                   sq_start,
  output logic [MOD_LEN-1:0]     sq_in,
  input  logic [SQ_OUT_BITS-1:0] sq_out,
  input  logic                   sq_valid,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SQ_OUT_BITS-1:0] res_sq,
  output logic [ITER_W-1:0]      res_iters,
  output logic [1:0]             res_status,
  output logic                   busy
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ABORT   = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_INVALID = 2'd3;

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [MOD_LEN-1:0]     r_sq_in;
  logic [ITER_W-1:0]      r_t;
  logic [ITER_W-1:0]      r_cnt;
  logic [ITER_W-1:0]      w_cnt_inc;
  logic [WD_W-1:0]        r_wdog;
  logic [WD_W-1:0]        w_wdog_inc;
  logic [SQ_OUT_BITS-1:0] r_res_sq;
  logic [1:0]             r_status;
  logic [1:0]             w_status_nxt;
  logic                   w_status_ld;
  logic                   w_accept;
  logic                   w_capture;
  logic                   w_wdog_clr;
  logic                   w_wdog_step;

  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_wdog_inc = r_wdog + 1'b1;

  assign sq_in      = r_sq_in;
  assign res_sq     = r_res_sq;
  assign res_iters  = r_cnt;
  assign res_status = r_status;

  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    w_status_ld  = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_wdog_clr   = 1'b0;
    w_wdog_step  = 1'b0;
    job_ready    = 1'b0;
    sq_start     = 1'b0;
    res_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
        if (job_valid) begin
          w_accept = 1'b1;
          if (job_iters == '0) begin
            w_state_nxt  = DONE;
            w_status_nxt = ST_INVALID;
            w_status_ld  = 1'b1;
          end else begin
            w_state_nxt = START;
          end
        end
      end
      START: begin
        sq_start   = 1'b1;
        w_wdog_clr = 1'b1;
        if (abort) begin
          w_state_nxt  = DONE;
          w_status_nxt = ST_ABORT;
          w_status_ld  = 1'b1;
        end else begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // A completing squaring wins over abort; any squaring pre-empts the watchdog.
        if (sq_valid) begin
          w_capture  = 1'b1;
          w_wdog_clr = 1'b1;
          if (w_cnt_inc == r_t) begin
            w_state_nxt  = DONE;
            w_status_nxt = ST_OK;
            w_status_ld  = 1'b1;
          end else if (abort) begin
            w_state_nxt  = DONE;
            w_status_nxt = ST_ABORT;
            w_status_ld  = 1'b1;
          end
        end else if (abort) begin
          w_state_nxt  = DONE;
          w_status_nxt = ST_ABORT;
          w_status_ld  = 1'b1;
        end else if (w_wdog_inc == WD_LIMIT) begin
          w_state_nxt  = DONE;
          w_status_nxt = ST_TIMEOUT;
          w_status_ld  = 1'b1;
        end else begin
          w_wdog_step = 1'b1;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sq_in  <= '0;
      r_t      <= '0;
      r_cnt    <= '0;
      r_wdog   <= '0;
      r_res_sq <= '0;
      r_status <= ST_OK;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_sq_in  <= job_x;
        r_t      <= job_iters;
        r_cnt    <= '0;
        r_res_sq <= '0;
      end
      if (w_capture) begin
        r_cnt    <= w_cnt_inc;
        r_res_sq <= sq_out;
      end
      if (w_wdog_clr) begin
        r_wdog <= '0;
      end else if (w_wdog_step) begin
        r_wdog <= w_wdog_inc;
      end
      if (w_status_ld) begin
        r_status <= w_status_nxt;
      end
    end
  end

endmodule

// File: tb/tb_modsq_sequencer.sv
// Randomized bench for modsq_sequencer: a job-level reference model predicts when each job ends and with what result.
module tb_modsq_sequencer;
  localparam int ML  = 64;
  localparam int SQB = (ML / 16 + 2) * 32;
  localparam int IW  = 8;
  localparam int TO  = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           job_valid;
  logic           job_ready;
  logic [ML-1:0]  job_x;
  logic [IW-1:0]  job_iters;
  logic           abort;
  logic           sq_start;
  logic [ML-1:0]  sq_in;
  logic [SQB-1:0] sq_out;
  logic           sq_valid;
  logic           res_valid;
  logic           res_ready;
  logic [SQB-1:0] res_sq;
  logic [IW-1:0]  res_iters;
  logic [1:0]     res_status;
  logic           busy;

  always #5 clk = ~clk;

  modsq_sequencer #(
    .MOD_LEN(ML), .SQ_OUT_BITS(SQB), .ITER_W(IW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_x(job_x), .job_iters(job_iters), .abort(abort), .sq_start(sq_start),
    .sq_in(sq_in), .sq_out(sq_out), .sq_valid(sq_valid), .res_valid(res_valid),
    .res_ready(res_ready), .res_sq(res_sq), .res_iters(res_iters),
    .res_status(res_status), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Job-level model: squarings done, cycles of silence since the last one, outcome.
  int             m_cnt;
  int             m_sil;
  bit             m_done;
  logic [1:0]     m_status;
  logic [SQB-1:0] m_last;

  task automatic check(input string tag, input logic [SQB-1:0] got, input logic [SQB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [SQB-1:0] rnd_wide();
    logic [SQB-1:0] v;
    for (int i = 0; i < SQB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_step(input bit sv, input bit ab, input logic [SQB-1:0] d, input int t);
    if (sv) begin
      m_cnt++;
      m_last = d;
      m_sil  = 0;
      if (m_cnt == t) begin m_done = 1'b1; m_status = 2'd0; end
      else if (ab)    begin m_done = 1'b1; m_status = 2'd1; end
    end else if (ab) begin
      m_done = 1'b1; m_status = 2'd1;
    end else begin
      m_sil++;
      if (m_sil == TO - 1) begin m_done = 1'b1; m_status = 2'd2; end
    end
  endtask

  task automatic check_reset_vals();
    check("rst_job_ready",  SQB'(job_ready),  SQB'(1'b1));
    check("rst_sq_start",   SQB'(sq_start),   '0);
    check("rst_res_valid",  SQB'(res_valid),  '0);
    check("rst_busy",       SQB'(busy),       '0);
    check("rst_res_status", SQB'(res_status), '0);
    check("rst_res_iters",  SQB'(res_iters),  '0);
    check("rst_res_sq",     res_sq,           '0);
    check("rst_sq_in",      SQB'(sq_in),      '0);
  endtask

  // mode: 0 pulse every cycle, 1 random pulses, 2 abort after 4 pulses, 3 one pulse then silence,
  //       4 abort together with the final pulse, 5 sparse pulses with random aborts, 6 abort in START, 7 very sparse
  task automatic run_job(input logic [ML-1:0] x, input int t, input int mode, input int hold);
    int             cyc;
    bit             sv;
    bit             ab;
    logic [SQB-1:0] d;
    cyc = 0;
    while (!job_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("job_ready_idle", SQB'(job_ready), SQB'(1'b1));
    job_x = x; job_iters = IW'(t); job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0; job_x = {$urandom, $urandom}; job_iters = IW'($urandom);
    check("sq_in_latch", SQB'(sq_in), SQB'(x));
    m_cnt = 0; m_sil = 0; m_done = 1'b0; m_status = 2'd0; m_last = '0;
    if (t == 0) begin
      check("invalid_no_start", SQB'(sq_start), '0);
      m_done = 1'b1; m_status = 2'd3;
    end else begin
      check("start_pulse", SQB'(sq_start), SQB'(1'b1));
      check("start_busy",  SQB'(busy),     SQB'(1'b1));
      sq_valid = 1'($urandom_range(0, 1));
      sq_out   = rnd_wide();
      if (mode == 6) begin
        abort = 1'b1; m_done = 1'b1; m_status = 2'd1;
      end
      @(negedge clk);
      sq_valid = 1'b0; abort = 1'b0;
      cyc = 0;
      while (!m_done && cyc < 5000) begin
        check("run_no_result", SQB'(res_valid), '0);
        check("run_no_start",  SQB'(sq_start),  '0);
        check("run_sq_in",     SQB'(sq_in),     SQB'(x));
        case (mode)
          0:       begin sv = 1'b1; ab = 1'b0; end
          2:       begin sv = (m_cnt < 4); ab = (m_cnt == 4); end
          3:       begin sv = (m_cnt == 0); ab = 1'b0; end
          4:       begin sv = 1'b1; ab = (m_cnt == t - 1); end
          5:       begin sv = ($urandom_range(0, 9) < 3); ab = ($urandom_range(0, 29) == 0); end
          7:       begin sv = ($urandom_range(0, 19) == 0); ab = 1'b0; end
          default: begin sv = 1'($urandom_range(0, 1)); ab = 1'b0; end
        endcase
        d = rnd_wide();
        sq_valid = sv; abort = ab; sq_out = d;
        model_step(sv, ab, d, t);
        @(negedge clk);
        sq_valid = 1'b0; abort = 1'b0;
        cyc++;
      end
    end
    check("done_valid",    SQB'(res_valid),  SQB'(1'b1));
    check("done_status",   SQB'(res_status), SQB'(m_status));
    check("done_iters",    SQB'(res_iters),  SQB'(m_cnt));
    check("done_sq",       res_sq,           m_last);
    check("done_no_ready", SQB'(job_ready),  '0);
    check("done_busy",     SQB'(busy),       SQB'(1'b1));
    check("done_no_start", SQB'(sq_start),   '0);
    for (int i = 0; i < hold; i++) begin
      sq_valid  = (i % 2 == 0);
      abort     = 1'($urandom_range(0, 1));
      job_valid = 1'($urandom_range(0, 1));
      sq_out    = rnd_wide();
      @(negedge clk);
      check("hold_valid",    SQB'(res_valid),  SQB'(1'b1));
      check("hold_status",   SQB'(res_status), SQB'(m_status));
      check("hold_iters",    SQB'(res_iters),  SQB'(m_cnt));
      check("hold_sq",       res_sq,           m_last);
      check("hold_no_ready", SQB'(job_ready),  '0);
    end
    sq_valid = 1'b0; abort = 1'b0; job_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("release_valid", SQB'(res_valid), '0);
    check("release_ready", SQB'(job_ready), SQB'(1'b1));
    check("release_busy",  SQB'(busy),      '0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not end within its time budget");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; job_valid = 1'b0; job_x = '0; job_iters = '0;
    abort = 1'b0; sq_out = '0; sq_valid = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_vals();

    run_job(64'd5, 3, 0, 0);
    run_job({$urandom, $urandom}, 0, 1, 2);
    run_job({$urandom, $urandom}, 10, 2, 3);
    run_job({$urandom, $urandom}, 2, 3, 0);
    run_job({$urandom, $urandom}, 3, 4, 0);
    run_job({$urandom, $urandom}, 6, 6, 1);

    // Reset in the middle of a job, with every other input trying to act in the same cycle.
    job_x = {$urandom, $urandom}; job_iters = IW'(5); job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    @(negedge clk);
    sq_valid = 1'b1; sq_out = rnd_wide();
    @(negedge clk);
    sq_valid = 1'b0;
    reset = 1'b1; job_valid = 1'b1; sq_valid = 1'b1; abort = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; job_valid = 1'b0; sq_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    check_reset_vals();

    run_job({$urandom, $urandom}, 4, 1, 20);
    run_job({$urandom, $urandom}, 2, 0, 0);
    run_job({$urandom, $urandom}, 255, 0, 0);

    for (int j = 0; j < 40; j++) begin
      int t;
      int mode;
      t = $urandom_range(0, 12);
      case ($urandom_range(0, 3))
        0:       mode = 1;
        1:       mode = 5;
        2:       mode = 7;
        default: mode = 4;
      endcase
      run_job({$urandom, $urandom}, t, mode, $urandom_range(0, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
